regfile_cmd_ctrl: RTL and testbench

Command sequencer directly upstream of the 8 x 16 `Register_File`. It accepts write, read and clear-all commands over a valid/ready handshake and drives the register file's `WrData`/`Address`/`WrEn`/`RdEn` port. It returns read data on a separate valid/ready response channel. Clear-all is an internal counter-driven burst that zeroes every entry.

---
 rtl/regfile_cmd_ctrl_pkg.sv | 23 ++
 rtl/regfile_cmd_ctrl_if.sv | 31 +++
 rtl/regfile_cmd_ctrl.sv | 118 +++++++++++
 tb/tb_regfile_cmd_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_cmd_ctrl_pkg.sv
// Shared definitions for the register file command controller:
// geometry defaults, opcodes and the controller state encoding.
package regfile_ctrl_pkg;

   localparam int RF_WIDTH  = 16;
   localparam int RF_DEPTH  = 8;
   localparam int RF_ADDR_W = $clog2(RF_DEPTH);

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_READ_WAIT,
      S_RESP,
      S_CLEAR
   } state_e;

endpackage

// File: rtl/regfile_cmd_ctrl_if.sv
// Command/response handshake bundle of the register file controller.
// master: command issuer and response consumer; slave: the controller.
interface regfile_cmd_if
   import regfile_ctrl_pkg::*;
#(
   parameter int WIDTH  = RF_WIDTH,
   parameter int ADDR_W = RF_ADDR_W
);

   logic              CmdValid;
   logic              CmdReady;
   logic [1:0]        CmdOp;
   logic [ADDR_W-1:0] CmdAddr;
   logic [WIDTH-1:0]  CmdData;
   logic              RspValid;
   logic              RspReady;
   logic [WIDTH-1:0]  RspData;
   logic [ADDR_W-1:0] RspAddr;
   logic              Busy;

   modport master (
      output CmdValid, CmdOp, CmdAddr, CmdData, RspReady,
      input  CmdReady, RspValid, RspData, RspAddr, Busy
   );

   modport slave (
      input  CmdValid, CmdOp, CmdAddr, CmdData, RspReady,
      output CmdReady, RspValid, RspData, RspAddr, Busy
   );

endinterface

// File: rtl/regfile_cmd_ctrl.sv
// Command sequencer in front of the 8x16 register file.
// Ports: CLK/RST, bus (cmd+rsp slave), Rf* register file port.
module regfile_cmd_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter int WIDTH  = RF_WIDTH,
   parameter int DEPTH  = RF_DEPTH,
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              CLK,
   input  logic              RST,
   regfile_cmd_if.slave      bus,
   output logic [WIDTH-1:0]  RfWrData,
   output logic [ADDR_W-1:0] RfAddress,
   output logic              RfWrEn,
   output logic              RfRdEn,
   input  logic [WIDTH-1:0]  RfRdData
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_e            r_state;
   state_e            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [WIDTH-1:0]  r_data;
   logic [ADDR_W-1:0] r_cnt;
   logic [WIDTH-1:0]  r_rsp_data;
   logic [ADDR_W-1:0] r_rsp_addr;
   logic              r_busy;
   logic              w_accept;
   logic              w_last;

   assign bus.CmdReady = (r_state == S_IDLE) && !RST;
   assign bus.RspData  = r_rsp_data;
   assign bus.RspAddr  = r_rsp_addr;
   assign bus.Busy     = r_busy;

   assign w_accept = bus.CmdValid && bus.CmdReady;
   assign w_last   = (r_cnt == LAST);

   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      RfWrEn       = 1'b0;
      RfRdEn       = 1'b0;
      RfWrData     = '0;
      RfAddress    = '0;
      bus.RspValid = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (bus.CmdOp)
                  OP_WRITE: w_next = S_WRITE;
                  OP_READ:  w_next = S_READ;
                  OP_CLEAR: w_next = S_CLEAR;
                  default:  w_next = S_IDLE;
               endcase
            end
         end
         S_WRITE: begin
            RfWrEn    = 1'b1;
            RfWrData  = r_data;
            RfAddress = r_addr;
            w_next    = S_IDLE;
         end
         S_READ: begin
            RfRdEn    = 1'b1;
            RfAddress = r_addr;
            w_next    = S_READ_WAIT;
         end
         S_READ_WAIT: begin
            w_next = S_RESP;
         end
         S_RESP: begin
            bus.RspValid = 1'b1;
            if (bus.RspReady) w_next = S_IDLE;
         end
         S_CLEAR: begin
            RfWrEn    = 1'b1;
            RfAddress = r_cnt;
            if (w_last) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_addr     <= '0;
         r_data     <= '0;
         r_cnt      <= '0;
         r_rsp_data <= '0;
         r_rsp_addr <= '0;
         r_busy     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr <= bus.CmdAddr;
            r_data <= bus.CmdData;
         end
         // counter returns to 0 after the last entry, so it is
         // already primed for the next clear burst
         if (w_accept && bus.CmdOp == OP_CLEAR)
            r_cnt <= '0;
         else if (r_state == S_CLEAR)
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         if (r_state == S_READ_WAIT) begin
            r_rsp_data <= RfRdData;
            r_rsp_addr <= r_addr;
         end
         r_busy <= (w_next != S_IDLE);
      end
   end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Bench for regfile_cmd_ctrl with a behavioural register file.
// Table of directed commands plus hand-written corner sequences.
module tb_regfile_cmd_ctrl;
   import regfile_ctrl_pkg::*;

   localparam int W  = RF_WIDTH;
   localparam int D  = RF_DEPTH;
   localparam int AW = RF_ADDR_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_cmd_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

   logic [W-1:0]  rf_wr_data;
   logic [W-1:0]  rf_rd_data;
   logic [AW-1:0] rf_addr;
   logic          rf_wr_en;
   logic          rf_rd_en;
   logic [W-1:0]  mem [D];

   regfile_cmd_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
      .CLK       (clk),
      .RST       (rst),
      .bus       (bus),
      .RfWrData  (rf_wr_data),
      .RfAddress (rf_addr),
      .RfWrEn    (rf_wr_en),
      .RfRdEn    (rf_rd_en),
      .RfRdData  (rf_rd_data)
   );

   always @(posedge clk) begin
      if (rf_wr_en) mem[rf_addr] <= rf_wr_data;
      if (rf_rd_en) rf_rd_data <= mem[rf_addr];
   end

   int   total = 0;
   int   bad   = 0;
   logic mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         total++;
         if (rf_wr_en && rf_rd_en) begin
            bad++;
            $display("FAIL excl: wr=%b rd=%b, required not both", rf_wr_en, rf_rd_en);
         end
         total++;
         if (!rf_wr_en && rf_wr_data != 0) begin
            bad++;
            $display("FAIL idle_data: got %0h required 0", rf_wr_data);
         end
         total++;
         if (!rf_wr_en && !rf_rd_en && rf_addr != 0) begin
            bad++;
            $display("FAIL idle_addr: got %0h required 0", rf_addr);
         end
         total++;
         if (bus.Busy !== !bus.CmdReady) begin
            bad++;
            $display("FAIL busy: got %b required %b", bus.Busy, !bus.CmdReady);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic [W-1:0] exp);
      int n;
      n = 0;
      while (!bus.CmdReady && n < 50) begin
         tick();
         n++;
      end
      chk("ready_wait", 32'(bus.CmdReady), 1);
      bus.CmdValid = 1'b1;
      bus.CmdOp    = op;
      bus.CmdAddr  = a;
      bus.CmdData  = d;
      tick();
      bus.CmdValid = 1'b0;
      case (op)
         OP_WRITE: begin
            chk("wr_en", 32'(rf_wr_en), 1);
            chk("wr_addr", 32'(rf_addr), 32'(a));
            chk("wr_data", 32'(rf_wr_data), 32'(d));
            tick();
            chk("wr_pulse", 32'(rf_wr_en), 0);
            chk("wr_ready", 32'(bus.CmdReady), 1);
         end
         OP_READ: begin
            chk("rd_en", 32'(rf_rd_en), 1);
            chk("rd_addr", 32'(rf_addr), 32'(a));
            tick();
            chk("rd_wait_en", 32'(rf_rd_en), 0);
            chk("rd_wait_valid", 32'(bus.RspValid), 0);
            tick();
            chk("rsp_valid", 32'(bus.RspValid), 1);
            chk("rsp_data", 32'(bus.RspData), 32'(exp));
            chk("rsp_addr", 32'(bus.RspAddr), 32'(a));
            tick();
            chk("rsp_drop", 32'(bus.RspValid), 0);
            chk("rd_ready", 32'(bus.CmdReady), 1);
         end
         OP_CLEAR: begin
            for (int i = 0; i < D; i++) begin
               chk("clr_en", 32'(rf_wr_en), 1);
               chk("clr_addr", 32'(rf_addr), i);
               chk("clr_data", 32'(rf_wr_data), 0);
               tick();
            end
            chk("clr_done_en", 32'(rf_wr_en), 0);
            chk("clr_ready", 32'(bus.CmdReady), 1);
         end
         default: begin
            chk("nop_ready", 32'(bus.CmdReady), 1);
            chk("nop_strobe", 32'(rf_wr_en | rf_rd_en), 0);
         end
      endcase
   endtask

   typedef struct {
      logic [1:0]    op;
      logic [AW-1:0] a;
      logic [W-1:0]  d;
      logic [W-1:0]  exp;
   } vec_t;

   vec_t tbl [8];

   initial begin
      tbl[0] = '{OP_WRITE, 3'd2, 16'd14,    16'd0};
      tbl[1] = '{OP_READ,  3'd2, 16'd0,     16'd14};
      tbl[2] = '{OP_WRITE, 3'd3, 16'd6,     16'd0};
      tbl[3] = '{OP_WRITE, 3'd7, 16'hFFFF,  16'd0};
      tbl[4] = '{OP_READ,  3'd3, 16'd0,     16'd6};
      tbl[5] = '{OP_READ,  3'd7, 16'd0,     16'hFFFF};
      tbl[6] = '{OP_READ,  3'd2, 16'd0,     16'd14};
      tbl[7] = '{OP_NOP,   3'd5, 16'h5A5A,  16'd0};

      bus.CmdValid = 1'b0;
      bus.CmdOp    = OP_NOP;
      bus.CmdAddr  = '0;
      bus.CmdData  = '0;
      bus.RspReady = 1'b1;
      rst = 1'b1;
      repeat (3) tick();

      chk("rst_ready", 32'(bus.CmdReady), 0);
      chk("rst_busy", 32'(bus.Busy), 0);
      chk("rst_rspv", 32'(bus.RspValid), 0);
      chk("rst_rspd", 32'(bus.RspData), 0);
      chk("rst_rspa", 32'(bus.RspAddr), 0);
      chk("rst_wr", 32'(rf_wr_en), 0);
      chk("rst_rd", 32'(rf_rd_en), 0);
      chk("rst_addr", 32'(rf_addr), 0);
      chk("rst_data", 32'(rf_wr_data), 0);
      rst = 1'b0;
      #1;
      chk("rel_ready", 32'(bus.CmdReady), 1);
      mon_en = 1'b1;

      for (int i = 0; i < 8; i++)
         send(tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].exp);

      // fill, clear, then every entry reads 0
      for (int a = 0; a < D; a++)
         send(OP_WRITE, AW'(a), W'(16'h1111 * (a + 1)), 16'd0);
      send(OP_CLEAR, 3'd0, 16'd0, 16'd0);
      for (int a = 0; a < D; a++)
         send(OP_READ, AW'(a), 16'd0, 16'd0);

      // response back-pressure with a command waiting
      send(OP_WRITE, 3'd5, 16'hABCD, 16'd0);
      bus.RspReady = 1'b0;
      bus.CmdValid = 1'b1;
      bus.CmdOp    = OP_READ;
      bus.CmdAddr  = 3'd5;
      tick();
      bus.CmdOp   = OP_WRITE;
      bus.CmdData = 16'h1234;
      chk("bp_rd_en", 32'(rf_rd_en), 1);
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", 32'(bus.RspValid), 1);
         chk("bp_data", 32'(bus.RspData), 32'h0000ABCD);
         chk("bp_addr", 32'(bus.RspAddr), 5);
         chk("bp_ready", 32'(bus.CmdReady), 0);
         chk("bp_wr", 32'(rf_wr_en), 0);
         tick();
      end
      chk("bp_hold", 32'(bus.RspValid), 1);
      bus.RspReady = 1'b1;
      tick();
      chk("bp_drop", 32'(bus.RspValid), 0);
      chk("bp_ready2", 32'(bus.CmdReady), 1);
      chk("bp_nowr", 32'(rf_wr_en), 0);
      tick();
      chk("bp_wr_acc", 32'(rf_wr_en), 1);
      chk("bp_wr_data", 32'(rf_wr_data), 32'h00001234);
      bus.CmdValid = 1'b0;
      tick();
      send(OP_READ, 3'd5, 16'd0, 16'h1234);

      // CmdValid held across a write: one accept per ready window
      bus.CmdValid = 1'b1;
      bus.CmdOp    = OP_WRITE;
      bus.CmdAddr  = 3'd1;
      bus.CmdData  = 16'h0055;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("hold_en", 32'(rf_wr_en), (k % 2 == 0) ? 1 : 0);
         chk("hold_ready", 32'(bus.CmdReady), (k % 2 == 0) ? 0 : 1);
      end
      bus.CmdValid = 1'b0;
      tick();
      chk("hold_idle_en", 32'(rf_wr_en), 0);
      chk("hold_idle_ready", 32'(bus.CmdReady), 1);
      send(OP_READ, 3'd1, 16'd0, 16'h0055);

      // reset in the middle of a clear burst
      for (int a = 0; a < D; a++)
         send(OP_WRITE, AW'(a), W'(16'h1111 * (a + 1)), 16'd0);
      bus.CmdValid = 1'b1;
      bus.CmdOp    = OP_CLEAR;
      tick();
      bus.CmdValid = 1'b0;
      repeat (3) tick();
      chk("mid_addr", 32'(rf_addr), 3);
      chk("mid_en", 32'(rf_wr_en), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(bus.CmdReady), 0);
      tick();
      rst = 1'b0;
      #1;
      chk("ar_wr", 32'(rf_wr_en), 0);
      chk("ar_rd", 32'(rf_rd_en), 0);
      chk("ar_addr", 32'(rf_addr), 0);
      chk("ar_rspv", 32'(bus.RspValid), 0);
      chk("ar_busy", 32'(bus.Busy), 0);
      chk("ar_ready", 32'(bus.CmdReady), 1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("ar_quiet", 32'(rf_wr_en), 0);
      end
      for (int a = 4; a < D; a++)
         send(OP_READ, AW'(a), 16'd0, W'(16'h1111 * (a + 1)));
      for (int a = 0; a < 3; a++)
         send(OP_READ, AW'(a), 16'd0, 16'd0);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
